// File: rtl/multicycle_alu_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The master side is the controller. The slave side is the datapath/IR.
interface multicycle_alu_controller_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       zero;
  logic [2:0] ALUControlE;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       ZFlag;
  logic       Halted;
  logic [3:0] StateDbg;

  modport master (
    input  Op, Funct, zero,
    output ALUControlE, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
           IRWrite, PCWrite, RegWrite, MemWrite, ZFlag, Halted, StateDbg
  );

  modport slave (
    output Op, Funct, zero,
    input  ALUControlE, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
           IRWrite, PCWrite, RegWrite, MemWrite, ZFlag, Halted, StateDbg
  );
endinterface

// File: rtl/multicycle_alu_controller.sv
// Multicycle control FSM. It sequences fetch/decode/execute/writeback over a single shared ALU
// and keeps the Z flag that conditional branches use.
module multicycle_alu_controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input logic clk,
  input logic reset,
  multicycle_alu_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  state_t     state_q, state_d;
  logic       z_q, z_d;

  logic [3:0] cmd;
  logic       cmd_legal;
  logic       cmd_is_cmp;
  logic [2:0] cmd_alu;

  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       halted;

  assign cmd = bus.Funct[4:1];

  always_comb begin
    cmd_legal  = 1'b1;
    cmd_is_cmp = 1'b0;
    cmd_alu    = ALU_ADD;
    case (cmd)
      4'b0100: cmd_alu = ALU_ADD;
      4'b0010: cmd_alu = ALU_SUB;
      4'b0000: cmd_alu = ALU_AND;
      4'b1100: cmd_alu = ALU_ORR;
      4'b1010: begin
        cmd_alu    = ALU_SUB;
        cmd_is_cmp = 1'b1;
      end
      default: cmd_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    alu_control = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    result_src  = RES_ALUOUT;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_FETCH: begin
        adr_src    = 1'b0;
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_FOUR;
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = SRCB_IMM;
        state_d   = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        state_d    = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_b   = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
        alu_control = cmd_alu;
        // Illegal commands leave Z untouched even when the S bit is set.
        if (cmd_legal) begin
          if (bus.Funct[0] || cmd_is_cmp) begin
            z_d = bus.zero;
          end
          state_d = cmd_is_cmp ? S_FETCH : S_ALUWB;
        end else begin
          state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        end
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        pc_write   = ~bus.Funct[4] | z_q;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase

    // The write enables are gated by reset so that an aborted instruction commits nothing.
    if (reset) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
    end
  end

  assign bus.ALUControlE = alu_control;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ResultSrc   = result_src;
  assign bus.AdrSrc      = adr_src;
  assign bus.IRWrite     = ir_write;
  assign bus.PCWrite     = pc_write;
  assign bus.RegWrite    = reg_write;
  assign bus.MemWrite    = mem_write;
  assign bus.ZFlag       = z_q;
  assign bus.Halted      = halted;
  assign bus.StateDbg    = state_q;

endmodule

// File: tb/tb_multicycle_alu_controller.sv
// Scoreboard bench: it drives a non-trapping controller and a trapping controller in lockstep.
// Each cycle it checks every control output of both against the expected state sequences.
module tb_multicycle_alu_controller;

  localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MW = 4'd4;
  localparam logic [3:0] MWR = 4'd5, ER = 4'd6, EI = 4'd7, AW = 4'd8, BR = 4'd9, HA = 4'd15;

  localparam logic [5:0] F_ADD   = 6'b0_0100_0;
  localparam logic [5:0] F_ADDSI = 6'b1_0100_1;
  localparam logic [5:0] F_SUB   = 6'b0_0010_0;
  localparam logic [5:0] F_ORRS  = 6'b0_1100_1;
  localparam logic [5:0] F_ANDI  = 6'b1_0000_0;
  localparam logic [5:0] F_CMP   = 6'b0_1010_0;
  localparam logic [5:0] F_BADS  = 6'b0_1111_1;
  localparam logic [5:0] F_LDR   = 6'b0_0000_1;
  localparam logic [5:0] F_STR   = 6'b0_0000_0;
  localparam logic [5:0] F_BEQ   = 6'b0_1000_0;
  localparam logic [5:0] F_BAL   = 6'b0_0000_0;

  typedef struct packed {
    logic [19:0] a;
    logic [19:0] b;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb_q[$];
  int   vec_count;
  int   miscompares;

  multicycle_alu_controller_if bus_a ();
  multicycle_alu_controller_if bus_b ();

  multicycle_alu_controller #(.ILLEGAL_TRAP(1'b0)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a.master)
  );

  multicycle_alu_controller #(.ILLEGAL_TRAP(1'b1)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // This is the per-state output table. ALUControlE in EXEC and PCWrite in BRANCH are supplied by the vector.
  function automatic logic [19:0] exp_vec(input logic [3:0] st, input logic rst,
                                          input logic [2:0] alu, input logic pcw_br,
                                          input logic z);
    logic [2:0] a;
    logic       sa, ad, irw, pcw, rw, mw, h;
    logic [1:0] sb, rs;
    a = 3'b000; sa = 1'b0; sb = 2'b00; rs = 2'b00; ad = 1'b0;
    irw = 1'b0; pcw = 1'b0; rw = 1'b0; mw = 1'b0; h = 1'b0;
    case (st)
      4'd0:  begin ad = 1'b0; irw = 1'b1; sa = 1'b1; sb = 2'b10; rs = 2'b10; pcw = 1'b1; end
      4'd1:  begin sa = 1'b1; sb = 2'b10; end
      4'd2:  sb = 2'b01;
      4'd3:  begin rs = 2'b00; ad = 1'b1; end
      4'd4:  begin rs = 2'b01; rw = 1'b1; end
      4'd5:  begin rs = 2'b00; ad = 1'b1; mw = 1'b1; end
      4'd6:  begin sb = 2'b00; a = alu; end
      4'd7:  begin sb = 2'b01; a = alu; end
      4'd8:  begin rs = 2'b00; rw = 1'b1; end
      4'd9:  begin sb = 2'b01; rs = 2'b10; pcw = pcw_br; end
      4'd15: h = 1'b1;
      default: ;
    endcase
    if (rst) begin
      irw = 1'b0; pcw = 1'b0; rw = 1'b0; mw = 1'b0;
    end
    return {st, a, sa, sb, rs, ad, irw, pcw, rw, mw, z, h};
  endfunction

  task automatic apply_stimulus(input logic rst, input logic [1:0] op, input logic [5:0] funct,
                                input logic zero, input logic [3:0] st_a, input logic [3:0] st_b,
                                input logic [2:0] alu, input logic pcw, input logic z);
    exp_t e;
    reset       = rst;
    bus_a.Op    = op;    bus_b.Op    = op;
    bus_a.Funct = funct; bus_b.Funct = funct;
    bus_a.zero  = zero;  bus_b.zero  = zero;
    e.a = exp_vec(st_a, rst, alu, pcw, z);
    e.b = exp_vec(st_b, rst, alu, pcw, z);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input exp_t e);
    logic [19:0] got_a, got_b;
    logic        bad;
    got_a = {bus_a.StateDbg, bus_a.ALUControlE, bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ResultSrc,
             bus_a.AdrSrc, bus_a.IRWrite, bus_a.PCWrite, bus_a.RegWrite, bus_a.MemWrite,
             bus_a.ZFlag, bus_a.Halted};
    got_b = {bus_b.StateDbg, bus_b.ALUControlE, bus_b.ALUSrcA, bus_b.ALUSrcB, bus_b.ResultSrc,
             bus_b.AdrSrc, bus_b.IRWrite, bus_b.PCWrite, bus_b.RegWrite, bus_b.MemWrite,
             bus_b.ZFlag, bus_b.Halted};
    bad = 1'b0;
    vec_count++;
    if (got_a !== e.a) begin
      $display("[TB] FAIL vec %0d nontrap_outputs: got %05h expected %05h", vec_count, got_a, e.a);
      bad = 1'b1;
    end
    if (got_b !== e.b) begin
      $display("[TB] FAIL vec %0d trap_outputs: got %05h expected %05h", vec_count, got_b, e.b);
      bad = 1'b1;
    end
    if (bad) miscompares++;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_count   = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus_a.Op = 2'b00; bus_a.Funct = F_ADD; bus_a.zero = 1'b0;
    bus_b.Op = 2'b00; bus_b.Funct = F_ADD; bus_b.zero = 1'b0;
    @(posedge clk);
    #1;

    // Reset is held for three checked cycles. The state is FETCH and every write enable is forced low.
    for (int i = 0; i < 3; i++) apply_stimulus(1, 2'b00, F_ADD, 0, FE, FE, 3'b000, 0, 0);

    // ADD (register operand): FETCH, DECODE, EXECR, ALUWB.
    apply_stimulus(0, 2'b00, F_ADD, 0, FE, FE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_ADD, 0, DE, DE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_ADD, 0, ER, ER, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_ADD, 0, AW, AW, 3'b000, 0, 0);

    // LDR and then STR.
    apply_stimulus(0, 2'b01, F_LDR, 0, FE, FE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b01, F_LDR, 0, DE, DE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b01, F_LDR, 0, MA, MA, 3'b000, 0, 0);
    apply_stimulus(0, 2'b01, F_LDR, 0, MR, MR, 3'b000, 0, 0);
    apply_stimulus(0, 2'b01, F_LDR, 0, MW, MW, 3'b000, 0, 0);
    apply_stimulus(0, 2'b01, F_STR, 0, FE, FE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b01, F_STR, 0, DE, DE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b01, F_STR, 0, MA, MA, 3'b000, 0, 0);
    apply_stimulus(0, 2'b01, F_STR, 0, MWR, MWR, 3'b000, 0, 0);

    // CMP with zero=1 sets Z, so the following BEQ is taken.
    apply_stimulus(0, 2'b00, F_CMP, 1, FE, FE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_CMP, 1, DE, DE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_CMP, 1, ER, ER, 3'b001, 0, 0);
    apply_stimulus(0, 2'b10, F_BEQ, 0, FE, FE, 3'b000, 0, 1);
    apply_stimulus(0, 2'b10, F_BEQ, 0, DE, DE, 3'b000, 0, 1);
    apply_stimulus(0, 2'b10, F_BEQ, 0, BR, BR, 3'b000, 1, 1);

    // CMP with zero=0 clears Z, so the following BEQ is not taken. An unconditional branch is still taken.
    apply_stimulus(0, 2'b00, F_CMP, 0, FE, FE, 3'b000, 0, 1);
    apply_stimulus(0, 2'b00, F_CMP, 0, DE, DE, 3'b000, 0, 1);
    apply_stimulus(0, 2'b00, F_CMP, 0, ER, ER, 3'b001, 0, 1);
    apply_stimulus(0, 2'b10, F_BEQ, 1, FE, FE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b10, F_BEQ, 1, DE, DE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b10, F_BEQ, 1, BR, BR, 3'b000, 0, 0);
    apply_stimulus(0, 2'b10, F_BAL, 0, FE, FE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b10, F_BAL, 0, DE, DE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b10, F_BAL, 0, BR, BR, 3'b000, 1, 0);

    // SUB without S ignores zero=1. ADDS (immediate) sets Z. ORRS with zero=0 clears Z.
    apply_stimulus(0, 2'b00, F_SUB, 1, FE, FE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_SUB, 1, DE, DE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_SUB, 1, ER, ER, 3'b001, 0, 0);
    apply_stimulus(0, 2'b00, F_SUB, 1, AW, AW, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_ADDSI, 1, FE, FE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_ADDSI, 1, DE, DE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_ADDSI, 1, EI, EI, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_ADDSI, 1, AW, AW, 3'b000, 0, 1);
    apply_stimulus(0, 2'b00, F_ORRS, 0, FE, FE, 3'b000, 0, 1);
    apply_stimulus(0, 2'b00, F_ORRS, 0, DE, DE, 3'b000, 0, 1);
    apply_stimulus(0, 2'b00, F_ORRS, 0, ER, ER, 3'b011, 0, 1);
    apply_stimulus(0, 2'b00, F_ORRS, 0, AW, AW, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_ANDI, 1, FE, FE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_ANDI, 1, DE, DE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_ANDI, 1, EI, EI, 3'b010, 0, 0);
    apply_stimulus(0, 2'b00, F_ANDI, 1, AW, AW, 3'b000, 0, 0);

    // For Op=11, the non-trapping controller loops FETCH/DECODE and the trapping controller stays halted.
    apply_stimulus(0, 2'b11, F_ADD, 0, FE, FE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b11, F_ADD, 0, DE, DE, 3'b000, 0, 0);
    for (int i = 0; i < 10; i++)
      apply_stimulus(0, 2'b11, F_ADD, 0, (i % 2 == 0) ? FE : DE, HA, 3'b000, 0, 0);
    apply_stimulus(1, 2'b11, F_ADD, 0, FE, HA, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_CMP, 1, FE, FE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_CMP, 1, DE, DE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_CMP, 1, ER, ER, 3'b001, 0, 0);

    // An illegal DP command with S=1 leaves Z unchanged. Only the trapping controller halts.
    apply_stimulus(0, 2'b00, F_BADS, 0, FE, FE, 3'b000, 0, 1);
    apply_stimulus(0, 2'b00, F_BADS, 0, DE, DE, 3'b000, 0, 1);
    apply_stimulus(0, 2'b00, F_BADS, 0, ER, ER, 3'b000, 0, 1);

    // Reset arrives during MEMWRITE. MemWrite is suppressed, and both controllers restart at FETCH with Z cleared.
    apply_stimulus(0, 2'b01, F_STR, 0, FE, HA, 3'b000, 0, 1);
    apply_stimulus(0, 2'b01, F_STR, 0, DE, HA, 3'b000, 0, 1);
    apply_stimulus(0, 2'b01, F_STR, 0, MA, HA, 3'b000, 0, 1);
    apply_stimulus(1, 2'b01, F_STR, 0, MWR, HA, 3'b000, 0, 1);
    apply_stimulus(0, 2'b00, F_ADD, 0, FE, FE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_ADD, 0, DE, DE, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_ADD, 0, ER, ER, 3'b000, 0, 0);
    apply_stimulus(0, 2'b00, F_ADD, 0, AW, AW, 3'b000, 0, 0);

    @(negedge clk);
    if (sb_q.size() != 0) begin
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
